// File: rtl/div23_recon_seq_pkg.sv
// Shared constants, FSM state type and step-count helper for the /23 reconstruction datapath.
package div23_pkg;

    localparam int DIVISOR     = 23;
    localparam int DEF_N       = 64;
    localparam int DEF_Q_W     = 60;
    localparam int DEF_R_W     = 5;
    localparam int DEF_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int step_count(input int q_w, input int digit_w);
        return q_w / digit_w;
    endfunction

endpackage

// File: rtl/div23_recon_seq_mac.sv
// div23_digit_mac: one Horner step, acc_next = (acc << DIGIT_W) + d*23 + (last ? r : 0).
// Purely combinational so the divider's self-check can reuse the same step.
module div23_digit_mac #(
    parameter int ACC_W   = 70,
    parameter int DIGIT_W = 4,
    parameter int R_W     = 5
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] d,
    input  logic               last,
    input  logic [R_W-1:0]     r,
    output logic [ACC_W-1:0]   acc_next
);

    logic [ACC_W-1:0] d_ext_s;
    logic [ACC_W-1:0] d_x23_s;
    logic [ACC_W-1:0] r_ext_s;

    assign d_ext_s = {{(ACC_W-DIGIT_W){1'b0}}, d};
    // 23 = 16 + 4 + 2 + 1, kept as shift-adds so no multiplier is inferred
    assign d_x23_s = (d_ext_s << 3'd4) + (d_ext_s << 3'd2) + (d_ext_s << 3'd1) + d_ext_s;
    assign r_ext_s = last ? {{(ACC_W-R_W){1'b0}}, r} : {ACC_W{1'b0}};
    assign acc_next = (acc << DIGIT_W) + d_x23_s + r_ext_s;

endmodule

// File: rtl/div23_recon_seq.sv
// div23_recon_seq: rebuilds x = q*23 + r by digit-serial Horner evaluation, MSB digit first.
// Define DIV23_RECON_CHECK_EN to register a range-error flag (r >= 23 or x >= 2^N) with the result.
module div23_recon_seq
    import div23_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int Q_W     = DEF_Q_W,
    parameter int R_W     = DEF_R_W,
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] in_q,
    input  logic [R_W-1:0] in_r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_x,
    output logic           out_err
);

`ifdef DIV23_RECON_CHECK_EN
    localparam int ACC_W = N + R_W + 1;
`else
    localparam int ACC_W = N + 1;
`endif
    localparam int STEPS = step_count(Q_W, DIGIT_W);
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if ((Q_W % DIGIT_W) != 0) begin : g_bad_digit_w
        $error("div23_recon_seq: DIGIT_W must divide Q_W");
    end

    state_t             state_r, state_s;
    logic [Q_W-1:0]     q_sh_r, q_sh_s;
    logic [R_W-1:0]     r_r, r_s;
    logic [ACC_W-1:0]   acc_r, acc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               in_ready_r, in_ready_s;
    logic               out_valid_r, out_valid_s;
    logic [N-1:0]       out_x_r, out_x_s;
    logic [DIGIT_W-1:0] d_s;
    logic               last_s;
    logic [ACC_W-1:0]   acc_next_s;

    assign d_s    = q_sh_r[Q_W-1 -: DIGIT_W];
    assign last_s = (cnt_r == CNT_LAST);

    div23_digit_mac #(
        .ACC_W   (ACC_W),
        .DIGIT_W (DIGIT_W),
        .R_W     (R_W)
    ) u_mac (
        .acc      (acc_r),
        .d        (d_s),
        .last     (last_s),
        .r        (r_r),
        .acc_next (acc_next_s)
    );

`ifdef DIV23_RECON_CHECK_EN
    localparam logic [R_W-1:0] DIV_R = R_W'(DIVISOR);
    logic out_err_r, out_err_s;
    logic range_err_s;

    // anything at or above bit N means the true result does not fit the output
    assign range_err_s = (r_r >= DIV_R) | (|acc_next_s[ACC_W-1:N]);
    assign out_err     = out_err_r;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_x     = out_x_r;

    // next-state and next-output logic; every register holds unless its state updates it
    always_comb begin
        state_s     = state_r;
        q_sh_s      = q_sh_r;
        r_s         = r_r;
        acc_s       = acc_r;
        cnt_s       = cnt_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        out_x_s     = out_x_r;
`ifdef DIV23_RECON_CHECK_EN
        out_err_s   = out_err_r;
`endif
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid && in_ready_r) begin
                    q_sh_s     = in_q;
                    r_s        = in_r;
                    acc_s      = {ACC_W{1'b0}};
                    cnt_s      = {CNT_W{1'b0}};
                    in_ready_s = 1'b0;
                    state_s    = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                in_ready_s = 1'b0;
                acc_s      = acc_next_s;
                q_sh_s     = q_sh_r << DIGIT_W;
                cnt_s      = cnt_r + CNT_ONE;
                if (last_s) begin
                    out_valid_s = 1'b1;
                    out_x_s     = acc_next_s[N-1:0];
`ifdef DIV23_RECON_CHECK_EN
                    out_err_s   = range_err_s;
`endif
                    state_s     = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // state and datapath registers; reset discards any partial result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            q_sh_r      <= {Q_W{1'b0}};
            r_r         <= {R_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_x_r     <= {N{1'b0}};
`ifdef DIV23_RECON_CHECK_EN
            out_err_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            q_sh_r      <= q_sh_s;
            r_r         <= r_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_x_r     <= out_x_s;
`ifdef DIV23_RECON_CHECK_EN
            out_err_r   <= out_err_s;
`endif
        end
    end

endmodule

// File: doc/div23_recon_seq.md
Name: div23_recon_seq

Overview:
- Inverse of the constant-divide-by-23 datapath: rebuilds the N-bit dividend from a quotient/remainder pair, x = q*23 + r.
- Digit-serial Horner evaluation, DIGIT_W quotient bits per cycle, MSB first.
- Used as the round-trip partner of the /23 divider: feeds reconstructed dividends back for self-check, and serves as a multiply-by-23-plus-offset unit elsewhere in the datapath.
- Valid/ready on both sides; one transaction in flight.

Parameters:
- N, 64: dividend/output width.
- Q_W, 60: quotient width (ceil(N - log2(23)); 2^64/23 < 2^60).
- R_W, 5: remainder width.
- DIGIT_W, 4: quotient bits consumed per cycle. Must divide Q_W; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  q/r valid.
- in_ready  out  1  block can accept a pair.
- in_q  in  Q_W  quotient.
- in_r  in  R_W  remainder.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_x  out  N  reconstructed dividend, low N bits.
- out_err  out  1  range error (see Optional Feature).

Behaviour:
- Reset values: in_ready=0 while rst=1 and 1 in the first cycle after release; out_valid=0, out_x=0, out_err=0. FSM goes to IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: load q into the shift register, r into r_reg, acc<=0, cnt<=0, go to RUN.
  - RUN: in_ready=0. Each cycle, d = top DIGIT_W bits of the shift register; acc <= (acc<<DIGIT_W) + d*23. On the last digit (cnt = Q_W/DIGIT_W - 1), also add r_reg in the same cycle. Shift q left by DIGIT_W; cnt++. After the last digit, go to DONE.
  - DONE: out_valid=1. out_x and out_err stay stable until out_valid&out_ready. On that handshake go to IDLE.
- acc width is N+R_W+1 so overflow is never lost internally. out_x = acc[N-1:0].
- d*23 is built as (d<<4)+(d<<2)+(d<<1)+d. No DSP inference is required.
- Latency: with in-handshake at edge 0, RUN occupies edges 1..Q_W/DIGIT_W. out_valid rises after edge Q_W/DIGIT_W (15 with the defaults). Back-to-back throughput is one result per Q_W/DIGIT_W+2 cycles.
- No input accepted outside IDLE. in_q/in_r are sampled only on the handshake; later changes are ignored.
- out_ready held low in DONE stalls indefinitely with no data loss.
- rst asserted in RUN or DONE aborts immediately to reset values. The partial result is discarded and no out_valid pulse is produced.
- out_valid never depends combinationally on out_ready. in_ready never depends combinationally on in_valid.

Optional Feature:
- Macro: DIV23_RECON_CHECK_EN.
- Defined: out_err is registered with the result, set when in_r >= 23 or acc >= 2^N (result does not fit N bits). out_x still carries the low N bits.
- Undefined: out_err tied to 0, no compare logic, and acc is trimmed to N+1 bits (wrap behaviour only).

Decomposition:
- Shared package div23_pkg: DIVISOR=23, N, Q_W, R_W, DIGIT_W defaults; FSM state enum (IDLE, RUN, DONE); function computing the step count Q_W/DIGIT_W.
- One natural sub-module: div23_digit_mac. It is combinational, computing acc_next = (acc<<DIGIT_W) + d*23 + (last ? r : 0). It is instantiated once, so it can also be reused by the divider's self-check.

Test Plan:
- q=0, r=0 -> out_x=0, out_err=0, out_valid exactly 15 cycles after the in-handshake.
- q=1, r=22 -> out_x=45. Then q=802032351030850070, r=5 -> out_x=0xFFFFFFFFFFFFFFFF, out_err=0.
- q=802032351030850070, r=6 -> out_x=0, out_err=1 with the macro; out_x=0, out_err=0 without it. Also q=5, r=23 -> out_x=138, out_err=1 with the macro.
- out_ready held low 40 cycles in DONE -> out_x/out_err stable and in_ready=0 throughout. One-cycle out_ready -> a single transfer, then in_ready=1 next cycle.
- rst pulsed at RUN cycle 7 -> all outputs 0 immediately, no spurious out_valid. A fresh q=10, r=3 afterwards -> out_x=233.
- Random 10k pairs (q < 2^60, r < 23) with random valid/ready stalls, scoreboard against q*23+r mod 2^64 -> zero mismatches, one output per accepted input, in order.
